// File: rtl/multi_timer_periph.sv
// Bus-mapped board peripheral: LED and digit registers, synchronized switches and
// N_TIMERS up-counting timer channels with reload, one-shot mode and W1C interrupts.
module multi_timer_periph #(
  parameter int unsigned N_TIMERS = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned LED_W    = 8,
  parameter int unsigned SW_W     = 8,
  parameter int unsigned DIGI_W   = 12,
  parameter logic [31:0] BASE     = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);
  localparam logic [31:0] OffLed   = 32'h00;
  localparam logic [31:0] OffSw    = 32'h04;
  localparam logic [31:0] OffDigi  = 32'h08;
  localparam logic [31:0] OffIrq   = 32'h0C;
  localparam logic [31:0] OffTimer = 32'h20;

  logic [31:0]         off;
  logic                hit_led, hit_sw, hit_digi, hit_irq;
  logic [N_TIMERS-1:0] hit_th, hit_tl, hit_tcon;

  logic [LED_W-1:0]    led_q, led_d;
  logic [DIGI_W-1:0]   digi_q, digi_d;
  logic [SW_W-1:0]     sw_meta_q, sw_sync_q;
  logic [N_TIMERS-1:0] irq_q, irq_d, ovf, irq_en;
  logic [CNT_W-1:0]    th_q [N_TIMERS];
  logic [CNT_W-1:0]    th_d [N_TIMERS];
  logic [CNT_W-1:0]    tl_q [N_TIMERS];
  logic [CNT_W-1:0]    tl_d [N_TIMERS];
  logic [2:0]          tcon_q [N_TIMERS];
  logic [2:0]          tcon_d [N_TIMERS];

  assign off      = addr - BASE;
  assign hit_led  = (off == OffLed);
  assign hit_sw   = (off == OffSw);
  assign hit_digi = (off == OffDigi);
  assign hit_irq  = (off == OffIrq);

  always_comb begin
    hit_th   = '0;
    hit_tl   = '0;
    hit_tcon = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      hit_th[i]   = (off == OffTimer + 32'(16 * i));
      hit_tl[i]   = (off == OffTimer + 32'(16 * i) + 32'h4);
      hit_tcon[i] = (off == OffTimer + 32'(16 * i) + 32'h8);
    end
  end

  // Counting uses pre-write state; bus writes are applied afterwards so they win,
  // while the overflow set of a status bit is applied after its W1C clear.
  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    irq_d  = irq_q;
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    ovf    = '0;
    if (wr && hit_led)  led_d  = wdata[LED_W-1:0];
    if (wr && hit_digi) digi_d = wdata[DIGI_W-1:0];
    if (wr && hit_irq)  irq_d  = irq_q & ~wdata[N_TIMERS-1:0];
    for (int i = 0; i < N_TIMERS; i++) begin
      ovf[i] = tcon_q[i][0] && (tl_q[i] == '1);
      if (ovf[i]) begin
        tl_d[i]  = th_q[i];
        irq_d[i] = 1'b1;
        if (tcon_q[i][2]) tcon_d[i][0] = 1'b0;
      end else if (tcon_q[i][0]) begin
        tl_d[i] = tl_q[i] + CNT_W'(1);
      end
      if (wr && hit_th[i])   th_d[i]   = wdata[CNT_W-1:0];
      if (wr && hit_tl[i])   tl_d[i]   = wdata[CNT_W-1:0];
      if (wr && hit_tcon[i]) tcon_d[i] = wdata[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q     <= '0;
      digi_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      irq_q     <= '0;
      th_q      <= '{default: '0};
      tl_q      <= '{default: '0};
      tcon_q    <= '{default: '0};
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      irq_q     <= irq_d;
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
    end
  end

  always_comb begin
    irq_en = '0;
    for (int i = 0; i < N_TIMERS; i++) irq_en[i] = tcon_q[i][1];
  end

  assign irqout = |(irq_q & irq_en);
  assign led    = led_q;
  assign digi   = digi_q;

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (hit_led)  rdata = 32'(led_q);
      if (hit_sw)   rdata = 32'(sw_sync_q);
      if (hit_digi) rdata = 32'(digi_q);
      if (hit_irq)  rdata = 32'(irq_q);
      for (int i = 0; i < N_TIMERS; i++) begin
        if (hit_th[i])   rdata = 32'(th_q[i]);
        if (hit_tl[i])   rdata = 32'(tl_q[i]);
        if (hit_tcon[i]) rdata = 32'(tcon_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_multi_timer_periph.sv
// Directed and randomized bench for multi_timer_periph against a register-level
// reference model kept in plain arrays.
module tb_multi_timer_periph;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  switch = '0;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_th [NT];
  logic [31:0] m_tl [NT];
  logic [2:0]  m_tcon [NT];
  logic [3:0]  m_irq = '0;
  logic [7:0]  m_led = '0;
  logic [11:0] m_digi = '0;
  logic [7:0]  m_sw1 = '0;
  logic [7:0]  m_sw2 = '0;

  logic [31:0] seq0 [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE,
                            32'hFFFF_FFFF, 32'hFFFF_FFFD};

  multi_timer_periph dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  always #50 clk = ~clk;

  // kind: 0 unmapped, 1 LED, 2 SWITCH, 3 DIGI, 4 IRQ, 5 TH, 6 TL, 7 TCON
  function automatic int m_decode(input logic [31:0] a, output int ch);
    logic [31:0] o;
    o  = a - BASE;
    ch = 0;
    if (o == 0)  return 1;
    if (o == 4)  return 2;
    if (o == 8)  return 3;
    if (o == 12) return 4;
    if (o >= 32 && o < 32 + 16 * NT && (o % 4) == 0 && (o % 16) < 12) begin
      ch = int'((o - 32) / 16);
      return 5 + int'((o % 16) / 4);
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int ch, kind;
    kind = m_decode(a, ch);
    case (kind)
      1: return 32'(m_led);
      2: return 32'(m_sw2);
      3: return 32'(m_digi);
      4: return 32'(m_irq);
      5: return m_th[ch];
      6: return m_tl[ch];
      7: return 32'(m_tcon[ch]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irqout();
    for (int i = 0; i < NT; i++) if (m_irq[i] && m_tcon[i][1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clock(input bit rst_n, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
    int kind, ch;
    logic [32:0] sum;
    logic [3:0] ovf;
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) begin
        m_th[i] = '0; m_tl[i] = '0; m_tcon[i] = '0;
      end
      m_irq = '0; m_led = '0; m_digi = '0; m_sw1 = '0; m_sw2 = '0;
      return;
    end
    m_sw2 = m_sw1;
    m_sw1 = switch;
    ovf = '0;
    for (int i = 0; i < NT; i++) begin
      if (m_tcon[i][0]) begin
        sum = {1'b0, m_tl[i]} + 33'd1;
        if (sum[32]) begin
          ovf[i]  = 1'b1;
          m_tl[i] = m_th[i];
          if (m_tcon[i][2]) m_tcon[i][0] = 1'b0;
        end else begin
          m_tl[i] = sum[31:0];
        end
      end
    end
    kind = m_decode(a, ch);
    if (w) begin
      case (kind)
        1: m_led = d[7:0];
        3: m_digi = d[11:0];
        4: m_irq = m_irq & ~d[3:0];
        5: m_th[ch] = d;
        6: m_tl[ch] = d;
        7: m_tcon[ch] = d[2:0];
        default: ;
      endcase
    end
    m_irq = m_irq | ovf;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst_n, input bit w, input logic [31:0] a,
                      input logic [31:0] d);
    reset = rst_n; wr = w; addr = a; wdata = d; rd = 1'b0;
    @(posedge clk);
    m_clock(rst_n, w, a, d);
    #1;
    wr = 1'b0;
    reset = 1'b1;
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
    step(1'b1, 1'b1, BASE + off, d);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, BASE, 32'h0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    check(tag, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".led"}, 32'(led), 32'(m_led));
    check({tag, ".digi"}, 32'(digi), 32'(m_digi));
    check({tag, ".irqout"}, 32'(irqout), 32'(m_irqout()));
    rd_check({tag, ".rd_led"}, BASE, m_read(BASE));
    rd_check({tag, ".rd_sw"}, BASE + 4, m_read(BASE + 4));
    rd_check({tag, ".rd_digi"}, BASE + 8, m_read(BASE + 8));
    rd_check({tag, ".rd_irq"}, BASE + 12, m_read(BASE + 12));
    for (int i = 0; i < NT; i++) begin
      rd_check({tag, ".th"}, BASE + 32'h20 + 32'(16 * i), m_read(BASE + 32'h20 + 32'(16 * i)));
      rd_check({tag, ".tl"}, BASE + 32'h24 + 32'(16 * i), m_read(BASE + 32'h24 + 32'(16 * i)));
      rd_check({tag, ".tcon"}, BASE + 32'h28 + 32'(16 * i), m_read(BASE + 32'h28 + 32'(16 * i)));
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0: return BASE;
      1: return BASE + 32'h4;
      2: return BASE + 32'h8;
      3: return BASE + 32'hC;
      4: return BASE + 32'h10;
      5: return BASE + 32'h2C;
      6: return BASE + 32'h60;
      7: return $urandom;
      default: return BASE + 32'h20 + 32'($urandom_range(0, 3)) * 16
                      + 32'($urandom_range(0, 2)) * 4;
    endcase
  endfunction

  initial begin
    logic [31:0] a, d;
    bit rn;
    for (int i = 0; i < NT; i++) begin
      m_th[i] = '0; m_tl[i] = '0; m_tcon[i] = '0;
    end

    // Reset state
    step(1'b0, 1'b0, BASE, 32'h0);
    step(1'b0, 1'b0, BASE, 32'h0);
    check_all("reset");
    check("reset.irqout_const", 32'(irqout), 32'h0);

    // Auto-reload sequence with interrupt
    wr_reg(32'h20, 32'hFFFF_FFFD);
    wr_reg(32'h24, 32'hFFFF_FFFE);
    wr_reg(32'h28, 32'h3);
    rd_check("ar.tl_start", BASE + 32'h24, 32'hFFFF_FFFE);
    for (int k = 0; k < 5; k++) begin
      idle();
      rd_check("ar.tl_seq", BASE + 32'h24, seq0[k]);
      check("ar.irqout", 32'(irqout), (k >= 1) ? 32'h1 : 32'h0);
    end
    rd_check("ar.status", BASE + 32'hC, 32'h1);
    wr_reg(32'h28, 32'h0);
    wr_reg(32'h0C, 32'hF);
    check_all("ar_done");

    // One-shot on channel 1
    wr_reg(32'h30, 32'h5);
    wr_reg(32'h34, 32'hFFFF_FFFF);
    wr_reg(32'h38, 32'h7);
    idle();
    rd_check("os.tl_reload", BASE + 32'h34, 32'h5);
    rd_check("os.tcon", BASE + 32'h38, 32'h6);
    idle();
    rd_check("os.tl_hold", BASE + 32'h34, 32'h5);
    check("os.irqout_set", 32'(irqout), 32'h1);
    wr_reg(32'h0C, 32'h2);
    check("os.irqout_clr", 32'(irqout), 32'h0);

    // Overflow coincident with W1C on channel 2: set wins
    wr_reg(32'h40, 32'h0);
    wr_reg(32'h44, 32'hFFFF_FFFE);
    wr_reg(32'h48, 32'h1);
    idle();
    wr_reg(32'h0C, 32'h4);
    rd_check("w1c.set_wins", BASE + 32'hC, 32'h4);
    wr_reg(32'h48, 32'h0);
    wr_reg(32'h0C, 32'h4);
    rd_check("w1c.cleared", BASE + 32'hC, 32'h0);

    // Bus writes colliding with overflow on channel 0
    wr_reg(32'h20, 32'h10);
    wr_reg(32'h24, 32'hFFFF_FFFE);
    wr_reg(32'h28, 32'h5);
    idle();
    wr_reg(32'h28, 32'h5);
    rd_check("col.tcon_wins", BASE + 32'h28, 32'h5);
    rd_check("col.tl_reload", BASE + 32'h24, 32'h10);
    rd_check("col.status", BASE + 32'hC, 32'h1);
    wr_reg(32'h0C, 32'h1);
    wr_reg(32'h24, 32'hFFFF_FFFF);
    wr_reg(32'h24, 32'h77);
    rd_check("col.tl_wins", BASE + 32'h24, 32'h77);
    rd_check("col.status2", BASE + 32'hC, 32'h1);
    rd_check("col.oneshot_off", BASE + 32'h28, 32'h4);
    wr_reg(32'h28, 32'h0);
    wr_reg(32'h0C, 32'hF);
    check_all("col_done");

    // Switch synchronizer latency and unmapped read
    switch = 8'hA5;
    rd_check("sw.lat0", BASE + 4, 32'h0);
    idle();
    rd_check("sw.lat1", BASE + 4, 32'h0);
    idle();
    rd_check("sw.lat2", BASE + 4, 32'hA5);
    rd_check("unmapped.0x10", BASE + 32'h10, 32'h0);

    // Reset mid-count overrides counting and an LED write
    wr_reg(32'h00, 32'h3C);
    wr_reg(32'h08, 32'hABC);
    rd = 1'b0; addr = BASE;
    #1;
    check("rd_low.zero", rdata, 32'h0);
    wr_reg(32'h24, 32'h100);
    wr_reg(32'h28, 32'h3);
    wr_reg(32'h54, 32'hFFFF_FFF0);
    wr_reg(32'h58, 32'h3);
    idle();
    step(1'b0, 1'b1, BASE, 32'hFF);
    check("rst.led", 32'(led), 32'h0);
    check("rst.digi", 32'(digi), 32'h0);
    check("rst.irqout", 32'(irqout), 32'h0);
    rd_check("rst.tl0", BASE + 32'h24, 32'h0);
    check_all("rst");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rn = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) switch = 8'($urandom);
      a = pick_addr();
      d = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom;
      step(rn, ($urandom_range(0, 2) != 0), a, d);
      check("rnd.led", 32'(led), 32'(m_led));
      check("rnd.digi", 32'(digi), 32'(m_digi));
      check("rnd.irqout", 32'(irqout), 32'(m_irqout()));
      a = pick_addr();
      rd_check("rnd.read", a, m_read(a));
      if (n % 50 == 49) check_all("rnd_all");
    end
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
